runner_motion_sequencer: RTL and testbench

- Converts one-cycle movement command codes from the input decoder into a frame-by-frame vertical trajectory for the running man.
- Sequences jump rise, apex hold, fall, fast drop and timed crouch.
- Advances once per frame_tick and publishes player height and pose flags to the renderer and collision logic.
- Owns the player's vertical state; it is the only writer of player_y.

---
 rtl/runner_motion_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_runner_motion_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/runner_motion_sequencer.sv
// runner_motion_sequencer
//   Turns one-cycle movement commands into a frame-by-frame vertical
//   trajectory for the running man: jump rise, apex hold, fall, fast drop
//   and timed crouch. State advances only on frame_tick cycles, and the
//   outputs are registered, so they change on the cycle after the tick.
//   This block is the only writer of player_y.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset
//   movement    command pulse: 000 none, 001 big jump, 010 small jump,
//               011 crouch, 100 drop; other codes are ignored
//   frame_tick  one-cycle pulse per game frame
//   player_y    height above ground (0 = on ground)
//   crouching   high while crouching
//   busy        high whenever the player is not standing on the ground
//   land_pulse  one-cycle pulse on the cycle after a landing tick
module runner_motion_sequencer #(
  parameter int Y_W           = 7,
  parameter int BIG_H         = 32,
  parameter int SMALL_H       = 16,
  parameter int RISE_STEP     = 2,
  parameter int FALL_STEP     = 2,
  parameter int DROP_STEP     = 4,
  parameter int APEX_FRAMES   = 3,
  parameter int CROUCH_FRAMES = 12
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [2:0]     movement,
  input  logic           frame_tick,
  output logic [Y_W-1:0] player_y,
  output logic           crouching,
  output logic           busy,
  output logic           land_pulse
);

  localparam int CNT_MAX = (APEX_FRAMES > CROUCH_FRAMES) ? APEX_FRAMES : CROUCH_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [2:0] CMD_NONE   = 3'b000;
  localparam logic [2:0] CMD_BIG    = 3'b001;
  localparam logic [2:0] CMD_SMALL  = 3'b010;
  localparam logic [2:0] CMD_CROUCH = 3'b011;
  localparam logic [2:0] CMD_DROP   = 3'b100;

  localparam logic [Y_W-1:0] BIG_Y   = Y_W'(BIG_H);
  localparam logic [Y_W-1:0] SMALL_Y = Y_W'(SMALL_H);
  localparam logic [Y_W-1:0] RISE_Y  = Y_W'(RISE_STEP);
  localparam logic [Y_W:0]   RISE_WY = (Y_W + 1)'(RISE_STEP);
  localparam logic [Y_W-1:0] FALL_Y  = Y_W'(FALL_STEP);
  localparam logic [Y_W-1:0] DROP_Y  = Y_W'(DROP_STEP);

  localparam logic [CNT_W-1:0] APEX_CNT   = CNT_W'(APEX_FRAMES);
  localparam logic [CNT_W-1:0] CROUCH_CNT = CNT_W'(CROUCH_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [2:0] {GROUND, RISE, APEX, FALL, DROP, CROUCH} state_t;

  state_t           state, state_next;
  logic [Y_W-1:0]   y_next;
  logic [Y_W-1:0]   target, target_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       pending_cmd, pending_next;
  logic             land_next;

  logic             cmd_legal;
  logic [2:0]       cmd;
  logic [Y_W-1:0]   jump_target;
  logic [Y_W-1:0]   jump_y;
  logic [Y_W:0]     rise_sum;
  logic [Y_W-1:0]   rise_y;
  logic [Y_W-1:0]   fall_y;
  logic [Y_W-1:0]   drop_y;

  // A legal code on the current cycle wins over anything already pending,
  // which also covers a command arriving on the tick cycle itself.
  assign cmd_legal = (movement != CMD_NONE) && (movement <= CMD_DROP);
  assign cmd       = cmd_legal ? movement : pending_cmd;

  assign jump_target = (cmd == CMD_BIG) ? BIG_Y : SMALL_Y;
  assign jump_y      = (RISE_Y >= jump_target) ? jump_target : RISE_Y;

  // Rise is computed one bit wider so the clamp sees the true sum.
  assign rise_sum = {1'b0, player_y} + RISE_WY;
  assign rise_y   = (rise_sum >= {1'b0, target}) ? target : rise_sum[Y_W-1:0];
  assign fall_y   = (player_y <= FALL_Y) ? '0 : player_y - FALL_Y;
  assign drop_y   = (player_y <= DROP_Y) ? '0 : player_y - DROP_Y;

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= GROUND;
      player_y    <= '0;
      target      <= '0;
      cnt         <= '0;
      pending_cmd <= '0;
      land_pulse  <= 1'b0;
    end else begin
      state       <= state_next;
      player_y    <= y_next;
      target      <= target_next;
      cnt         <= cnt_next;
      pending_cmd <= pending_next;
      land_pulse  <= land_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next   = state;
    y_next       = player_y;
    target_next  = target;
    cnt_next     = cnt;
    land_next    = 1'b0;
    pending_next = cmd;

    if (frame_tick) begin
      // Whatever was pending is consumed (or discarded) by this tick.
      pending_next = '0;
      case (state)
        // GROUND and CROUCH accept the same commands; CROUCH additionally
        // counts down when no command arrives.
        GROUND, CROUCH: begin
          if (cmd == CMD_BIG || cmd == CMD_SMALL) begin
            state_next  = RISE;
            target_next = jump_target;
            y_next      = jump_y;
          end else if (cmd == CMD_CROUCH) begin
            state_next = CROUCH;
            cnt_next   = CROUCH_CNT;
          end else if (state == CROUCH) begin
            if (cnt == CNT_ONE) state_next = GROUND;
            else                cnt_next   = cnt - CNT_ONE;
          end
        end
        RISE: begin
          if (cmd == CMD_DROP) begin
            state_next = DROP;
          end else begin
            y_next = rise_y;
            if (rise_y == target) begin
              state_next = APEX;
              cnt_next   = APEX_CNT;
            end
          end
        end
        APEX: begin
          if (cmd == CMD_DROP)    state_next = DROP;
          else if (cnt == CNT_ONE) state_next = FALL;
          else                     cnt_next   = cnt - CNT_ONE;
        end
        FALL: begin
          if (cmd == CMD_DROP) begin
            state_next = DROP;
          end else begin
            y_next = fall_y;
            if (fall_y == '0) begin
              state_next = GROUND;
              land_next  = 1'b1;
            end
          end
        end
        DROP: begin
          y_next = drop_y;
          if (drop_y == '0) begin
            state_next = GROUND;
            land_next  = 1'b1;
          end
        end
        default: state_next = GROUND;
      endcase
    end
  end

  // Output decode
  always_comb begin
    crouching = (state == CROUCH);
    busy      = (state != GROUND);
  end

endmodule

// File: tb/tb_runner_motion_sequencer.sv
module tb_runner_motion_sequencer;

  localparam int Y_W           = 7;
  localparam int BIG_H         = 32;
  localparam int SMALL_H       = 16;
  localparam int RISE_STEP     = 2;
  localparam int FALL_STEP     = 2;
  localparam int DROP_STEP     = 4;
  localparam int APEX_FRAMES   = 3;
  localparam int CROUCH_FRAMES = 12;

  localparam int M_GROUND = 0;
  localparam int M_RISE   = 1;
  localparam int M_APEX   = 2;
  localparam int M_FALL   = 3;
  localparam int M_DROP   = 4;
  localparam int M_CROUCH = 5;

  logic           clk        = 1'b0;
  logic           reset      = 1'b1;
  logic [2:0]     movement   = 3'd0;
  logic           frame_tick = 1'b0;
  logic [Y_W-1:0] player_y;
  logic           crouching;
  logic           busy;
  logic           land_pulse;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  runner_motion_sequencer #(
    .Y_W          (Y_W),
    .BIG_H        (BIG_H),
    .SMALL_H      (SMALL_H),
    .RISE_STEP    (RISE_STEP),
    .FALL_STEP    (FALL_STEP),
    .DROP_STEP    (DROP_STEP),
    .APEX_FRAMES  (APEX_FRAMES),
    .CROUCH_FRAMES(CROUCH_FRAMES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .movement  (movement),
    .frame_tick(frame_tick),
    .player_y  (player_y),
    .crouching (crouching),
    .busy      (busy),
    .land_pulse(land_pulse)
  );

  // Behavioural model: plain integer trajectory per frame.
  typedef struct {
    int mode;
    int y;
    int tgt;
    int cnt;
    int pend;
    bit land;
  } mdl_t;

  mdl_t m;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int step_down(input int y, input int s);
    return (y <= s) ? 0 : y - s;
  endfunction

  function automatic mdl_t model_step(input mdl_t s, input int mv, input bit tk, input bit rst);
    mdl_t n;
    int   c;
    n      = s;
    n.land = 1'b0;
    if (rst) begin
      n = '{default: 0};
      return n;
    end
    c = (mv >= 1 && mv <= 4) ? mv : s.pend;
    if (!tk) begin
      n.pend = c;
      return n;
    end
    n.pend = 0;
    case (s.mode)
      M_GROUND, M_CROUCH: begin
        if (c == 1 || c == 2) begin
          n.tgt  = (c == 1) ? BIG_H : SMALL_H;
          n.y    = imin(RISE_STEP, n.tgt);
          n.mode = M_RISE;
        end else if (c == 3) begin
          n.mode = M_CROUCH;
          n.cnt  = CROUCH_FRAMES;
        end else if (s.mode == M_CROUCH) begin
          if (s.cnt == 1) n.mode = M_GROUND;
          else            n.cnt  = s.cnt - 1;
        end
      end
      M_RISE: begin
        if (c == 4) n.mode = M_DROP;
        else begin
          n.y = imin(s.y + RISE_STEP, s.tgt);
          if (n.y == s.tgt) begin
            n.mode = M_APEX;
            n.cnt  = APEX_FRAMES;
          end
        end
      end
      M_APEX: begin
        if (c == 4)          n.mode = M_DROP;
        else if (s.cnt == 1) n.mode = M_FALL;
        else                 n.cnt  = s.cnt - 1;
      end
      default: begin
        if (s.mode == M_FALL && c == 4) n.mode = M_DROP;
        else begin
          n.y = step_down(s.y, (s.mode == M_FALL) ? FALL_STEP : DROP_STEP);
          if (n.y == 0) begin
            n.mode = M_GROUND;
            n.land = 1'b1;
          end
        end
      end
    endcase
    return n;
  endfunction

  initial m = '{default: 0};

  always @(posedge clk) m <= model_step(m, int'(movement), frame_tick, reset);

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model.player_y",   int'(player_y),   m.y);
      chk("model.crouching",  int'(crouching),  int'(m.mode == M_CROUCH));
      chk("model.busy",       int'(busy),       int'(m.mode != M_GROUND));
      chk("model.land_pulse", int'(land_pulse), int'(m.land));
    end
  end

  task automatic expect_out(input string nm, input int y, input int cr, input int bz, input int ld);
    chk({nm, ".y"},    int'(player_y),   y);
    chk({nm, ".crch"}, int'(crouching),  cr);
    chk({nm, ".busy"}, int'(busy),       bz);
    chk({nm, ".land"}, int'(land_pulse), ld);
  endtask

  task automatic gap();
    movement   = 3'd0;
    frame_tick = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic send(input logic [2:0] c);
    movement   = c;
    frame_tick = 1'b0;
    @(negedge clk); #1;
    movement = 3'd0;
  endtask

  // One idle cycle, then a tick cycle carrying command c; returns one
  // cycle after the tick so its registered result is visible.
  task automatic tick(input logic [2:0] c);
    gap();
    movement   = c;
    frame_tick = 1'b1;
    @(negedge clk); #1;
    movement   = 3'd0;
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick(3'd0);
  endtask

  initial begin
    reset = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk); #1;
    expect_out("reset", 0, 0, 0, 0);
    reset = 1'b0;
    gap();

    // Big jump
    tick(3'b001);   expect_out("big.t1", 2, 0, 1, 0);
    ticks(15);      expect_out("big.t16", 32, 0, 1, 0);
    ticks(3);       expect_out("big.t19", 32, 0, 1, 0);
    tick(3'b000);   expect_out("big.t20", 30, 0, 1, 0);
    ticks(14);      expect_out("big.t34", 2, 0, 1, 0);
    tick(3'b000);   expect_out("big.t35", 0, 0, 0, 1);
    gap();          expect_out("big.after", 0, 0, 0, 0);

    // Small jump, command coincident with the tick
    tick(3'b010);   expect_out("small.t1", 2, 0, 1, 0);
    ticks(7);       expect_out("small.t8", 16, 0, 1, 0);
    ticks(10);      expect_out("small.t18", 2, 0, 1, 0);
    tick(3'b000);   expect_out("small.t19", 0, 0, 0, 1);

    // Drop mid-rise
    tick(3'b001);
    ticks(4);       expect_out("drop.y10", 10, 0, 1, 0);
    tick(3'b100);   expect_out("drop.enter", 10, 0, 1, 0);
    tick(3'b000);   expect_out("drop.d1", 6, 0, 1, 0);
    tick(3'b000);   expect_out("drop.d2", 2, 0, 1, 0);
    tick(3'b000);   expect_out("drop.land", 0, 0, 0, 1);

    // Plain crouch
    tick(3'b011);   expect_out("crouch.t0", 0, 1, 1, 0);
    ticks(11);      expect_out("crouch.t11", 0, 1, 1, 0);
    tick(3'b000);   expect_out("crouch.exit", 0, 0, 0, 0);

    // Crouch extended at tick 6
    tick(3'b011);
    ticks(5);
    tick(3'b011);
    ticks(11);      expect_out("ext.t17", 0, 1, 1, 0);
    tick(3'b000);   expect_out("ext.t18", 0, 0, 0, 0);

    // Crouch cancelled by a jump at tick 4
    tick(3'b011);
    ticks(3);
    tick(3'b001);   expect_out("cancel.t4", 2, 0, 1, 0);
    ticks(34);      expect_out("cancel.land", 0, 0, 0, 1);

    // Later code overwrites earlier pending code
    send(3'b011);
    send(3'b001);
    tick(3'b000);   expect_out("ovr.jump", 2, 0, 1, 0);
    ticks(34);      expect_out("ovr.land", 0, 0, 0, 1);

    // Drop on the ground is ignored
    tick(3'b100);   expect_out("gnd.drop", 0, 0, 0, 0);

    // Illegal code neither latches nor overwrites
    send(3'b011);
    send(3'b101);
    tick(3'b000);   expect_out("illegal.crouch", 0, 1, 1, 0);
    ticks(12);      expect_out("illegal.exit", 0, 0, 0, 0);

    // Jump during fall is discarded and not replayed after landing
    tick(3'b001);
    ticks(21);      expect_out("fall.t22", 26, 0, 1, 0);
    tick(3'b001);   expect_out("fall.t23", 24, 0, 1, 0);
    send(3'b001);
    ticks(11);      expect_out("fall.t34", 2, 0, 1, 0);
    tick(3'b000);   expect_out("fall.land", 0, 0, 0, 1);
    tick(3'b000);   expect_out("fall.noreplay", 0, 0, 0, 0);

    // Reset mid-air
    tick(3'b001);
    ticks(24);      expect_out("rst.y20", 20, 0, 1, 0);
    reset = 1'b1;
    @(negedge clk); #1;
    reset = 1'b0;
    expect_out("rst.after", 0, 0, 0, 0);
    tick(3'b000);   expect_out("rst.tick", 0, 0, 0, 0);

    gap();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
